// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to four result ports per cycle in
// round-robin order and broadcasts them, registered, on a 4-slot flat CDB.
module cdb_arbiter #(
   parameter int N_REQ = 6,
   parameter int PTR_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [N_REQ-1:0]     req_valid_flat,
   input  logic [4*N_REQ-1:0]   req_rob_index_flat,
   input  logic [16*N_REQ-1:0]  req_result_flat,
   output logic [N_REQ-1:0]     req_ready_flat,
   output logic [3:0]           cdb_valid_flat,
   output logic [15:0]          cdb_rob_index_flat,
   output logic [63:0]          cdb_result_flat,
   output logic [2:0]           grant_count
);

   // Handshake: a result moves from requester r when req_valid[r] and
   // req_ready[r] are both high in the same cycle; the requester holds
   // valid, index and result stable until it sees ready.

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]       cdb_valid_q, cdb_valid_d;
   logic [15:0]      cdb_rob_q, cdb_rob_d;
   logic [63:0]      cdb_result_q, cdb_result_d;
   logic [2:0]       grant_count_q, grant_count_d;

   int dist_v [N_REQ];
   int rank_v [N_REQ];
   int last_dist_v;
   int last_idx_v;

   always_comb begin
      req_ready_flat = '0;
      cdb_valid_d    = '0;
      cdb_rob_d      = '0;
      cdb_result_d   = '0;
      grant_count_d  = '0;
      rr_ptr_d       = rr_ptr_q;
      last_dist_v    = -1;
      last_idx_v     = 0;

      // Distance of each requester from the pointer in circular scan order.
      for (int i = 0; i < N_REQ; i++) begin
         if (i >= int'(rr_ptr_q)) dist_v[i] = i - int'(rr_ptr_q);
         else                     dist_v[i] = i + N_REQ - int'(rr_ptr_q);
      end

      // Rank = number of valid requesters scanned before this one = its slot.
      for (int i = 0; i < N_REQ; i++) begin
         rank_v[i] = 0;
         for (int j = 0; j < N_REQ; j++) begin
            if (req_valid_flat[j] && (dist_v[j] < dist_v[i])) rank_v[i] = rank_v[i] + 1;
         end
      end

      for (int i = 0; i < N_REQ; i++) begin
         req_ready_flat[i] = !rst && !flush && req_valid_flat[i] && (rank_v[i] < 4);
         if (req_ready_flat[i]) begin
            grant_count_d = grant_count_d + 3'd1;
            if (dist_v[i] > last_dist_v) begin
               last_dist_v = dist_v[i];
               last_idx_v  = i;
            end
            for (int s = 0; s < 4; s++) begin
               if (rank_v[i] == s) begin
                  cdb_valid_d[3-s]              = 1'b1;
                  cdb_rob_d[4*(3-s) +: 4]       = req_rob_index_flat[4*i +: 4];
                  cdb_result_d[16*(3-s) +: 16]  = req_result_flat[16*i +: 16];
               end
            end
         end
      end

      if (last_dist_v >= 0) begin
         rr_ptr_d = (last_idx_v == N_REQ - 1) ? '0 : PTR_W'(last_idx_v + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         cdb_valid_q   <= '0;
         cdb_rob_q     <= '0;
         cdb_result_q  <= '0;
         grant_count_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         cdb_valid_q   <= cdb_valid_d;
         cdb_rob_q     <= cdb_rob_d;
         cdb_result_q  <= cdb_result_d;
         grant_count_q <= grant_count_d;
      end
   end

   assign cdb_valid_flat     = cdb_valid_q;
   assign cdb_rob_index_flat = cdb_rob_q;
   assign cdb_result_flat    = cdb_result_q;
   assign grant_count        = grant_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived vector table, a fairness sequence and
// random traffic checked against a queue-based round-robin model.
module tb_cdb_arbiter;
   localparam int N = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [N-1:0]      req_valid_flat;
   logic [4*N-1:0]    req_rob_index_flat;
   logic [16*N-1:0]   req_result_flat;
   logic [N-1:0]      req_ready_flat;
   logic [3:0]        cdb_valid_flat;
   logic [15:0]       cdb_rob_index_flat;
   logic [63:0]       cdb_result_flat;
   logic [2:0]        grant_count;

   cdb_arbiter #(.N_REQ(N), .PTR_W(3)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .req_valid_flat     (req_valid_flat),
      .req_rob_index_flat (req_rob_index_flat),
      .req_result_flat    (req_result_flat),
      .req_ready_flat     (req_ready_flat),
      .cdb_valid_flat     (cdb_valid_flat),
      .cdb_rob_index_flat (cdb_rob_index_flat),
      .cdb_result_flat    (cdb_result_flat),
      .grant_count        (grant_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int m_ptr = 0;
   logic [N-1:0]    m_ready;
   logic [86:0]     exp_q[$];

   logic [N-1:0]    cur_v;
   logic [4*N-1:0]  cur_rob;
   logic [16*N-1:0] cur_res;

   typedef struct {
      logic [5:0]  v;
      logic [23:0] rob;
      logic [95:0] res;
      logic        fl;
      logic        rs;
      logic [5:0]  e_ready;
      logic [3:0]  e_cv;
      logic [15:0] e_rob;
      logic [63:0] e_res;
      logic [2:0]  e_cnt;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // driver + model: one clock cycle, returns what the DUT showed
   task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] rb,
                       input logic [16*N-1:0] rs_v, input logic fl, input logic rr,
                       output logic [N-1:0] rd_seen, output logic [86:0] cdb_seen);
      int order[$];
      int gr[$];
      int ix;
      logic [3:0]  ev;
      logic [15:0] erob;
      logic [63:0] eres;
      @(negedge clk);
      req_valid_flat     = v;
      req_rob_index_flat = rb;
      req_result_flat    = rs_v;
      flush              = fl;
      rst                = rr;
      // model: list valid requesters in circular order from the pointer, keep first four
      m_ready = '0;
      ev = '0; erob = '0; eres = '0;
      if (!rr && !fl) begin
         for (int k = 0; k < N; k++) begin
            ix = (m_ptr + k) % N;
            if (v[ix]) order.push_back(ix);
         end
         foreach (order[k]) if (gr.size() < 4) gr.push_back(order[k]);
      end
      foreach (gr[s]) begin
         ix = gr[s];
         m_ready[ix] = 1'b1;
         ev = ev | (4'b1000 >> s);
         erob[4*(3-s) +: 4]   = rb[4*ix +: 4];
         eres[16*(3-s) +: 16] = rs_v[16*ix +: 16];
      end
      if (rr) m_ptr = 0;
      else if (gr.size() > 0) m_ptr = (gr[gr.size()-1] + 1) % N;
      exp_q.push_back({ev, erob, eres, 3'(gr.size())});
      #1;
      rd_seen = req_ready_flat;
      chk("ready", 128'(req_ready_flat), 128'(m_ready));
      chk("max4", 128'($countones(req_ready_flat) <= 4), 128'(1));
      @(posedge clk);
      #1;
      cdb_seen = {cdb_valid_flat, cdb_rob_index_flat, cdb_result_flat, grant_count};
      chk("cdb", 128'(cdb_seen), 128'(exp_q.pop_front()));
   endtask

   // requester behaviour: hold an ungranted result, otherwise choose a new one
   task automatic gen(input bit fair_mode);
      bit holding, nv;
      for (int r = 0; r < N; r++) begin
         holding = cur_v[r] && !m_ready[r];
         if (!holding) begin
            if (fair_mode) nv = (r == N - 1) ? 1'b1 : !cur_v[r];
            else           nv = ($urandom_range(0, 99) < 60);
            cur_v[r] = nv;
            if (nv) begin
               cur_rob[4*r +: 4]   = 4'($urandom_range(0, 15));
               cur_res[16*r +: 16] = 16'($urandom);
            end
         end
      end
   endtask

   initial begin
      logic [N-1:0] rd;
      logic [86:0]  cs;
      int wait5;
      rst = 1'b1; flush = 1'b0;
      req_valid_flat = '0; req_rob_index_flat = '0; req_result_flat = '0;

      tbl[0]  = '{6'b111111, 24'h543210, 96'h1005_1004_1003_1002_1001_1000, 1'b0, 1'b0,
                  6'b001111, 4'b1111, 16'h0123, 64'h1000_1001_1002_1003, 3'd4};
      tbl[1]  = '{6'b110011, 24'h543210, 96'h1005_1004_0000_0000_2001_2000, 1'b0, 1'b0,
                  6'b110011, 4'b1111, 16'h4501, 64'h1004_1005_2000_2001, 3'd4};
      tbl[2]  = '{6'b001000, 24'h009000, 96'h0000_0000_BEEF_0000_0000_0000, 1'b0, 1'b0,
                  6'b001000, 4'b1000, 16'h9000, 64'hBEEF_0000_0000_0000, 3'd1};
      tbl[3]  = '{6'b011111, 24'h543210, 96'h0000_3004_3003_3002_3001_3000, 1'b1, 1'b0,
                  6'b000000, 4'b0000, 16'h0000, 64'h0, 3'd0};
      tbl[4]  = '{6'b011111, 24'h543210, 96'h0000_3004_3003_3002_3001_3000, 1'b0, 1'b0,
                  6'b010111, 4'b1111, 16'h4012, 64'h3004_3000_3001_3002, 3'd4};
      tbl[5]  = '{6'b111111, 24'h543210, 96'h1005_1004_1003_1002_1001_1000, 1'b0, 1'b1,
                  6'b000000, 4'b0000, 16'h0000, 64'h0, 3'd0};
      tbl[6]  = '{6'b111111, 24'h543210, 96'h4005_4004_4003_4002_4001_4000, 1'b0, 1'b0,
                  6'b001111, 4'b1111, 16'h0123, 64'h4000_4001_4002_4003, 3'd4};
      tbl[7]  = '{6'b110000, 24'h543210, 96'h4005_4004_0000_0000_0000_0000, 1'b0, 1'b0,
                  6'b110000, 4'b1100, 16'h4500, 64'h4004_4005_0000_0000, 3'd2};
      tbl[8]  = '{6'b000000, 24'h000000, 96'h0, 1'b0, 1'b0,
                  6'b000000, 4'b0000, 16'h0000, 64'h0, 3'd0};
      tbl[9]  = '{6'b000001, 24'h00000A, 96'h0000_0000_0000_0000_0000_CAFE, 1'b0, 1'b0,
                  6'b000001, 4'b1000, 16'hA000, 64'hCAFE_0000_0000_0000, 3'd1};
      tbl[10] = '{6'b100001, 24'h500007, 96'h5555_0000_0000_0000_0000_7777, 1'b0, 1'b0,
                  6'b100001, 4'b1100, 16'h5700, 64'h5555_7777_0000_0000, 3'd2};

      // reset: outputs must be zero
      step('0, '0, '0, 1'b0, 1'b1, rd, cs);
      step('1, '1, '1, 1'b1, 1'b1, rd, cs);
      chk("reset_cdb", 128'(cs), 128'(0));

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].v, tbl[i].rob, tbl[i].res, tbl[i].fl, tbl[i].rs, rd, cs);
         chk($sformatf("tv%0d_ready", i), 128'(rd), 128'(tbl[i].e_ready));
         chk($sformatf("tv%0d_cdb", i), 128'(cs),
             128'({tbl[i].e_cv, tbl[i].e_rob, tbl[i].e_res, tbl[i].e_cnt}));
      end

      // fairness: requester 5 held valid while 0..4 toggle
      cur_v = '0; cur_rob = '0; cur_res = '0; m_ready = '0;
      wait5 = 0;
      for (int c = 0; c < 20; c++) begin
         gen(1'b1);
         step(cur_v, cur_rob, cur_res, 1'b0, 1'b0, rd, cs);
         if (m_ready[N-1]) begin
            chk("fair5", 128'(wait5 < 2), 128'(1));
            wait5 = 0;
         end else begin
            wait5++;
         end
      end

      // random traffic with occasional flush and reset
      for (int c = 0; c < 400; c++) begin
         gen(1'b0);
         step(cur_v, cur_rob, cur_res, 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 49) == 0), rd, cs);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 4-slot common data bus (CDB) among N_REQ functional-unit result ports.
- Each cycle, grants up to 4 pending results in round-robin order and drives them registered onto the flattened CDB.
- Reservation stations and the ROB snoop the CDB.
- Non-granted units hold their result until granted; flush drops in-flight broadcasts.

Parameters:
- N_REQ, 6, number of requesting functional-unit result ports (legal range 4..8).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= N_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (mispredict).
- req_valid_flat  input  N_REQ  bit r = requester r holds a result.
- req_rob_index_flat  input  4*N_REQ  requester r ROB index at [4r+3:4r].
- req_result_flat  input  16*N_REQ  requester r result at [16r+15:16r].
- req_ready_flat  output  N_REQ  bit r = requester r granted this cycle (combinational).
- cdb_valid_flat  output  4  slot s valid at bit 3-s.
- cdb_rob_index_flat  output  16  slot s ROB index at [4(3-s)+3:4(3-s)].
- cdb_result_flat  output  64  slot s result at [16(3-s)+15:16(3-s)].
- grant_count  output  3  number of slots valid on the CDB this cycle (0..4), registered.

Behaviour:
- Slot packing: slot 0 occupies the MSB field of each flat bus, matching the reservation-station unpacking (cdb_valid[3-n] = flat bit n).
- Handshake:
  - Transfer from requester r occurs when req_valid[r] & req_ready[r] in the same cycle.
  - Requesters hold valid, index and result stable until they see ready.
  - req_ready is combinational from req_valid, rr_ptr, rst and flush.
- Arbitration:
  - Scan requesters circularly starting at rr_ptr: rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first 4 requesters with valid=1 are granted.
  - The k-th granted requester (k = 0..3, in scan order) is assigned slot k.
- Latency: a result granted in cycle t appears on the CDB in cycle t+1 (one register stage).
- Output fields:
  - Unused slots drive valid 0, rob_index 0, result 0.
  - grant_count equals the popcount of cdb_valid_flat.
- Pointer update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - If no grant: rr_ptr unchanged.
- Fairness: any requester holding valid is granted within ceil(N_REQ/4) cycles.
- Flush (rst=0, flush=1):
  - All req_ready = 0; no grants.
  - Next cycle: CDB valid bits 0, fields 0, grant_count 0.
  - rr_ptr unchanged.
  - Requesters remain responsible for dropping their own valid.
- Reset (rst=1):
  - All req_ready = 0.
  - Next cycle: rr_ptr 0, all CDB outputs 0, grant_count 0.
  - rst overrides flush.
  - Reset mid-operation discards any pending grant.
- No pending requests: CDB idles with all zeros.
- Fewer than 4 requesters valid: all are granted, remaining slots invalid.
- Duplicate ROB indices across requesters are not checked; they are forwarded as given.
- No X on outputs after the first reset cycle.

Test Plan:
- Reset then all 6 valid, rob indices 0..5, results 0x1000+r, rr_ptr 0:
  - Cycle 1 ready = 0b001111.
  - Cycle 2 cdb_valid_flat = 4'b1111, cdb_rob_index_flat = 16'h0123, cdb_result_flat[63:48] = 0x1000, grant_count = 4.
- Continue with requesters 4,5 valid and 0,1 re-asserted with new values:
  - Grants 4,5,0,1 in slot order, so cdb_rob_index_flat = 16'h4501 (next results).
  - rr_ptr becomes 2.
- Only requester 3 valid (rob 0x9, result 0xBEEF):
  - Next cycle cdb_valid_flat = 4'b1000, cdb_rob_index_flat = 16'h9000, cdb_result_flat = 64'hBEEF_0000_0000_0000, grant_count = 1.
  - rr_ptr = 4.
- Flush asserted with 5 requesters valid:
  - req_ready_flat = 0.
  - Next cycle cdb_valid_flat = 0, grant_count = 0.
  - rr_ptr unchanged.
  - After flush deasserts, granting resumes from the same pointer.
- Requester 5 held valid while 0..4 toggle valid every cycle for 20 cycles:
  - Requester 5 granted within 2 cycles on every occasion.
  - No cycle shows more than 4 grants.
  - Each valid result appears exactly once on the CDB.
- Assert rst while all requesters valid mid-stream:
  - req_ready = 0 that cycle.
  - Next cycle all outputs 0 and rr_ptr 0.
  - First post-reset grants are 0,1,2,3.
